// File: rtl/uart_rx_buffer.sv
// UART 8N1 receiver: two-flop line synchronizer, mid-bit sampling FSM,
// and a first-word-fall-through receive FIFO drained by a pop strobe.
module uart_rx_buffer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              rx_serial,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rxState_t;

  logic            rxMeta;
  logic            rxS;
  rxState_t        state;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      shiftReg;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] rdPtr;

  logic stopSample;
  logic pushReq;
  logic pop;
  logic pushOk;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
    end else begin
      rxMeta <= rx_serial;
      rxS    <= rxMeta;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shiftReg  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxS) state <= START;
        end
        START: begin
          // Confirm the start bit at its midpoint; a high line here is a glitch.
          if (cnt == HALF) begin
            cnt <= '0;
            idx <= '0;
            state <= rxS ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt <= '0;
            shiftReg[idx] <= rxS;
            idx <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            frame_err <= ~rxS;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stopSample = (state == STOP) && (cnt == LAST);
  assign pushReq    = stopSample && rxS;
  assign pop        = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign pushOk     = pushReq && (!full || pop);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= pushReq && full && !pop;
      if (pushOk) begin
        mem[wrPtr] <= shiftReg;
        wrPtr <= wrPtr + ADDR_W'(1);
      end
      if (pop) rdPtr <= rdPtr + ADDR_W'(1);
      unique case ({pushOk, pop})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rdPtr];
  assign empty   = (count == '0);
  assign full    = (count == DEPTH);

endmodule
